// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - default bus widths and timeout
//   - FSM state encoding (plain constants so older tools and dumps stay compatible)
//   - helper to tell whether a state keeps an imem read outstanding
package fetch_pkg;

    localparam int unsigned DEFAULT_ADDR_W  = 32;
    localparam int unsigned DEFAULT_INSTR_W = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // Width of the imem-ack timeout counter; TIMEOUT must fit in it.
    localparam int unsigned TIMER_W = 8;

    typedef logic [2:0] fetchState_t;

    localparam fetchState_t IDLE    = 3'd0;
    localparam fetchState_t REQ     = 3'd1;
    localparam fetchState_t ADV     = 3'd2;
    localparam fetchState_t DISCARD = 3'd3;
    localparam fetchState_t ERR     = 3'd4;

    // A read stays requested until acked, even once its data is unwanted.
    function automatic logic reqActive(input fetchState_t state);
        return (state == REQ) || (state == DISCARD);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage and its neighbours.
//   imem_req/imem_addr -> instruction memory, imem_ack/imem_rdata <- memory
//   instr_valid/instr/instr_pc -> decode, instr_ready <- decode
// master: the fetch stage; slave: memory + decode side (testbench or wrapper).
interface instruction_fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned INSTR_W = DEFAULT_INSTR_W
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instruction} pairs between fetch and decode.
//   clk, rst_n        clock, async active-low reset (clears storage too)
//   push/pushPc/pushInstr  write one pair (ignored when full)
//   pop               remove the head (ignored when empty)
//   clear             drop all entries; overrides push and pop
//   count             number of valid entries (0..2)
//   headPc/headInstr  oldest entry
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ADDR_W-1:0]  pushPc,
    input  logic [INSTR_W-1:0] pushInstr,
    input  logic               pop,
    input  logic               clear,
    output logic [1:0]         count,
    output logic [ADDR_W-1:0]  headPc,
    output logic [INSTR_W-1:0] headInstr
);

    logic [ADDR_W-1:0]  pcMem    [2];
    logic [INSTR_W-1:0] instrMem [2];
    logic               wrPtr;
    logic               rdPtr;
    logic [1:0]         countQ;
    logic               doPush;
    logic               doPop;

    assign doPush = push && (countQ != 2'd2);
    assign doPop  = pop && (countQ != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcMem[0]    <= '0;
            pcMem[1]    <= '0;
            instrMem[0] <= '0;
            instrMem[1] <= '0;
            wrPtr       <= 1'b0;
            rdPtr       <= 1'b0;
            countQ      <= 2'd0;
        end else if (clear) begin
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            countQ <= 2'd0;
        end else begin
            if (doPush) begin
                pcMem[wrPtr]    <= pushPc;
                instrMem[wrPtr] <= pushInstr;
                wrPtr           <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            if (doPush && !doPop) begin
                countQ <= countQ + 2'd1;
            end else if (!doPush && doPop) begin
                countQ <= countQ - 2'd1;
            end
        end
    end

    assign count     = countQ;
    assign headPc    = pcMem[rdPtr];
    assign headInstr = instrMem[rdPtr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage between the program counter and decode.
// Latches pc, reads one instruction over a req/ack memory port, queues
// {pc, instr} for decode and pulses pc_advance so the PC stage steps on.
//   clk, rst_n   clock, async active-low reset
//   pc           current PC (word address, used verbatim)
//   flush        redirect: pc already holds the target; queue and any
//                in-flight read are discarded
//   pc_advance   one-cycle pulse after each accepted instruction
//   fetch_err    sticky: memory did not ack within TIMEOUT cycles
//   bus          imem request/response and decode handshake (master side)
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned INSTR_W = DEFAULT_INSTR_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT  // 1..255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              pc_advance,
    output logic              fetch_err,
    instruction_fetch_if.master bus
);

    // The request is dropped on the edge where the counter would reach TIMEOUT,
    // so imem_req is high for exactly TIMEOUT cycles.
    localparam logic [TIMER_W-1:0] TimeoutLast = TIMER_W'(TIMEOUT - 1);

    fetchState_t        stateQ, stateD;
    logic [ADDR_W-1:0]  addrQ, addrD;
    logic [TIMER_W-1:0] timerQ, timerD;

    logic               qPush;
    logic               qPop;
    logic [1:0]         qCount;
    logic [ADDR_W-1:0]  headPc;
    logic [INSTR_W-1:0] headInstr;

    always_comb begin
        stateD = stateQ;
        addrD  = addrQ;
        timerD = timerQ;
        qPush  = 1'b0;
        case (stateQ)
            IDLE: begin
                // At most one read outstanding, so count<2 guarantees room.
                if (!flush && (qCount != 2'd2)) begin
                    addrD  = pc;
                    timerD = '0;
                    stateD = REQ;
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    if (!flush) begin
                        qPush  = 1'b1;
                        stateD = ADV;
                    end else begin
                        stateD = IDLE;
                    end
                end else if (timerQ == TimeoutLast) begin
                    stateD = ERR;
                end else if (flush) begin
                    // Keep the request up until its ack, then throw the data away.
                    timerD = '0;
                    stateD = DISCARD;
                end else begin
                    timerD = timerQ + 1'b1;
                end
            end
            DISCARD: begin
                if (bus.imem_ack) begin
                    stateD = IDLE;
                end else if (timerQ == TimeoutLast) begin
                    stateD = ERR;
                end else begin
                    timerD = timerQ + 1'b1;
                end
            end
            ADV: begin
                stateD = IDLE;
            end
            ERR: begin
                stateD = ERR;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            addrQ  <= '0;
            timerQ <= '0;
        end else begin
            stateQ <= stateD;
            addrQ  <= addrD;
            timerQ <= timerD;
        end
    end

    assign qPop = (qCount != 2'd0) && bus.instr_ready;

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (qPush),
        .pushPc    (addrQ),
        .pushInstr (bus.imem_rdata),
        .pop       (qPop),
        .clear     (flush),
        .count     (qCount),
        .headPc    (headPc),
        .headInstr (headInstr)
    );

    assign bus.imem_req    = reqActive(stateQ);
    assign bus.imem_addr   = addrQ;
    assign bus.instr_valid = (qCount != 2'd0);
    assign bus.instr       = headInstr;
    assign bus.instr_pc    = headPc;
    assign pc_advance      = (stateQ == ADV);
    assign fetch_err       = (stateQ == ERR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table-driven streaming check plus hand-written
// redirect / back-pressure / timeout / reset sequences. Expected decode
// pairs are pushed by a PC-stage model and popped on each decode handshake.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          flush = 1'b0;
    logic          pc_advance;
    logic          fetch_err;

    instruction_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instruction_fetch #(
        .ADDR_W  (AW),
        .INSTR_W (IW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .flush      (flush),
        .pc_advance (pc_advance),
        .fetch_err  (fetch_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Memory: acks after memLat extra cycles of req; data = 0xA0000000 + addr.
    logic        memEnable = 1'b1;
    int unsigned memLat = 0;
    int unsigned waitCnt = 0;

    assign bus.imem_ack   = memEnable && bus.imem_req && (waitCnt == memLat);
    assign bus.imem_rdata = 32'hA000_0000 + bus.imem_addr;

    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) waitCnt <= waitCnt + 1;
        else                               waitCnt <= 0;
    end

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } pair_t;

    typedef struct {
        logic          ready;
        logic          expReq;
        logic          expAdv;
        logic          expValid;
        logic [AW-1:0] expAddr;
    } vec_t;

    pair_t expQ[$];
    int    checks = 0;
    int    failures = 0;
    int    advCount = 0;
    int    reqRise = 0;
    int    popCount = 0;
    logic  reqPrev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs already set for the coming posedge.
    task automatic tick();
        pair_t e;
        if (bus.instr_valid && bus.instr_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual_pc=%0h required=none", bus.instr_pc);
            end else begin
                e = expQ.pop_front();
                popCount++;
                chk("pop_pc", bus.instr_pc, e.pc);
                chk("pop_instr", bus.instr, e.instr);
            end
        end
        if (dut.qPush && (dut.qCount == 2'd2)) begin
            failures++;
            $display("FAIL push_into_full actual_count=%0d required=<2", dut.qCount);
        end
        @(posedge clk);
        @(negedge clk);
        if (bus.imem_req && !reqPrev) reqRise++;
        reqPrev = bus.imem_req;
        // PC stage: latch next PC on the negedge of the advance pulse.
        if (pc_advance) begin
            advCount++;
            expQ.push_back('{pc: pc, instr: 32'hA000_0000 + pc});
            pc = pc + 1;
        end
    endtask

    task automatic doReset(input logic [AW-1:0] startPc);
        rst_n = 1'b0;
        flush = 1'b0;
        pc = startPc;
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reqPrev = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        logic found;
        int   reqHigh;

        // Zero-wait memory, decode always ready: IDLE, REQ, ADV repeating.
        vecs[0] = '{ready: 1'b1, expReq: 1'b0, expAdv: 1'b0, expValid: 1'b0, expAddr: 32'd0};
        vecs[1] = '{ready: 1'b1, expReq: 1'b1, expAdv: 1'b0, expValid: 1'b0, expAddr: 32'd0};
        vecs[2] = '{ready: 1'b1, expReq: 1'b0, expAdv: 1'b1, expValid: 1'b1, expAddr: 32'd0};
        vecs[3] = '{ready: 1'b1, expReq: 1'b0, expAdv: 1'b0, expValid: 1'b0, expAddr: 32'd0};
        vecs[4] = '{ready: 1'b1, expReq: 1'b1, expAdv: 1'b0, expValid: 1'b0, expAddr: 32'd1};
        vecs[5] = '{ready: 1'b1, expReq: 1'b0, expAdv: 1'b1, expValid: 1'b1, expAddr: 32'd1};
        vecs[6] = '{ready: 1'b1, expReq: 1'b0, expAdv: 1'b0, expValid: 1'b0, expAddr: 32'd1};
        vecs[7] = '{ready: 1'b1, expReq: 1'b1, expAdv: 1'b0, expValid: 1'b0, expAddr: 32'd2};
        vecs[8] = '{ready: 1'b1, expReq: 1'b0, expAdv: 1'b1, expValid: 1'b1, expAddr: 32'd2};

        // Reset values.
        bus.instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_adv", pc_advance, 0);
        chk("rst_err", fetch_err, 0);
        rst_n = 1'b1;

        // Streaming.
        for (int i = 0; i < 9; i++) begin
            bus.instr_ready = vecs[i].ready;
            chk($sformatf("t1_req[%0d]", i), bus.imem_req, vecs[i].expReq);
            chk($sformatf("t1_adv[%0d]", i), pc_advance, vecs[i].expAdv);
            chk($sformatf("t1_valid[%0d]", i), bus.instr_valid, vecs[i].expValid);
            chk($sformatf("t1_addr[%0d]", i), bus.imem_addr, vecs[i].expAddr);
            tick();
        end
        chk("t1_pops", popCount, 3);

        // Back-pressure: queue fills, then one pop lets exactly one fetch through.
        memLat = 2;
        bus.instr_ready = 1'b0;
        doReset(0);
        advCount = 0;
        for (int i = 0; i < 40 && advCount < 2; i++) tick();
        chk("t2_two_fetched", advCount, 2);
        reqRise = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_no_req_when_full", reqRise, 0);
        chk("t2_req_low", bus.imem_req, 0);
        chk("t2_count_full", dut.qCount, 2);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        reqRise = 0;
        advCount = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("t2_one_new_req", reqRise, 1);
        chk("t2_one_new_adv", advCount, 1);
        popCount = 0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t2_drained_two", popCount >= 2, 1);

        // Flush while REQ waits: read finishes as DISCARD, then fetch at 0x40.
        memLat = 4;
        bus.instr_ready = 1'b1;
        doReset(32'h10);
        tick();
        chk("t3_req_first", bus.imem_req, 1);
        chk("t3_addr_first", bus.imem_addr, 32'h10);
        tick();
        flush = 1'b1;
        pc = 32'h40;
        expQ.delete();
        tick();
        flush = 1'b0;
        advCount = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_req_held[%0d]", i), bus.imem_req, 1);
            chk($sformatf("t3_no_valid[%0d]", i), bus.instr_valid, 0);
            tick();
        end
        chk("t3_req_done", bus.imem_req, 0);
        chk("t3_no_valid_after", bus.instr_valid, 0);
        tick();
        chk("t3_no_adv", advCount, 0);
        chk("t3_req_new", bus.imem_req, 1);
        chk("t3_addr_new", bus.imem_addr, 32'h40);
        popCount = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("t3_new_popped", popCount >= 1, 1);

        // Flush on the same edge as an ack with one entry queued.
        memLat = 2;
        bus.instr_ready = 1'b0;
        doReset(0);
        advCount = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (advCount == 1 && bus.imem_req && bus.imem_ack) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t4_ack_found", found, 1);
        chk("t4_one_queued", bus.instr_valid, 1);
        flush = 1'b1;
        expQ.delete();
        tick();
        flush = 1'b0;
        chk("t4_queue_empty", bus.instr_valid, 0);
        chk("t4_count_zero", dut.qCount, 0);
        chk("t4_no_adv", pc_advance, 0);
        chk("t4_state_idle", dut.stateQ, IDLE);
        chk("t4_adv_total", advCount, 1);
        tick();
        chk("t4_refetch_req", bus.imem_req, 1);
        chk("t4_refetch_addr", bus.imem_addr, 1);

        // Memory never acks.
        memEnable = 1'b0;
        bus.instr_ready = 1'b1;
        doReset(0);
        reqHigh = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.imem_req) reqHigh++;
            tick();
        end
        chk("t5_req_cycles", reqHigh, TO);
        chk("t5_req_dropped", bus.imem_req, 0);
        chk("t5_err", fetch_err, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t5_err_after_flush", fetch_err, 1);
        chk("t5_state_err", dut.stateQ, ERR);
        rst_n = 1'b0;
        #1;
        chk("t5_err_cleared", fetch_err, 0);
        memEnable = 1'b1;

        // Reset mid-request with one entry queued.
        memLat = 2;
        bus.instr_ready = 1'b0;
        doReset(0);
        advCount = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (advCount == 1 && bus.imem_req) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_second_req", found, 1);
        chk("t6_one_queued", bus.instr_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", bus.imem_req, 0);
        chk("t6_valid_async", bus.instr_valid, 0);
        chk("t6_addr_async", bus.imem_addr, 0);
        chk("t6_instr_async", bus.instr, 0);
        chk("t6_instr_pc_async", bus.instr_pc, 0);
        chk("t6_adv_async", pc_advance, 0);
        chk("t6_count_async", dut.qCount, 0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        reqPrev = 1'b0;
        chk("t6_idle_after_release", bus.imem_req, 0);
        tick();
        chk("t6_restart_req", bus.imem_req, 1);
        chk("t6_restart_addr", bus.imem_addr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
